// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-resource multicycle MIPS datapath.
// Handles wait-stated memory through a req/ready handshake and traps a hung access with a watchdog.
module multicycle_ctrl #(
    parameter int OPW      = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           regwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           instr_done,
    output logic           illegal,
    output logic           bus_err,
    output logic [3:0]     state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd12;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    localparam bit             WD_EN      = (MAX_WAIT > 0);
    localparam int             CW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_LIMIT = CW'(MAX_WAIT);

    logic [3:0]    state_q, state_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          req_state;
    logic          timeout;

    // Request is a pure function of state, so the watchdog never sees the reset gating.
    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = WD_EN && req_state && !mem_ready && (wait_q == WAIT_LIMIT);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_RTYPE)                  state_d = S_RTYPEEX;
                else if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_BEQ)               state_d = S_BEQEX;
                else if (op == OP_ADDI)              state_d = S_ADDIEX;
                else if (op == OP_J)                 state_d = S_JEX;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_TRAP;
        endcase
        if (timeout) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
            bus_err_d = 1'b1;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!WD_EN || !req_state || mem_ready) begin
            wait_d = '0;
        end else if (wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

    // Moore decode; only the FETCH load strobes and the store retirement follow mem_ready.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        state      = 4'd0;
        if (reset) begin
            illegal = illegal_q;
            bus_err = bus_err_q;
            state   = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE:  alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RTYPEWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQEX: begin
                    alusrca    = 1'b1;
                    aluop      = 2'b01;
                    branch     = 1'b1;
                    pcsrc      = 2'b01;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JEX: begin
                    pcwrite    = 1'b1;
                    pcsrc      = 2'b10;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified memory port, one register file.
- Decodes the 6-bit opcode held in the instruction register.
- Drives per-state datapath strobes and mux selects.
- Handles wait-stated memory through a req/ready handshake, with a watchdog that traps hung accesses.

Parameters:
- OPW, 6, opcode width.
- MAX_WAIT, 15, maximum cycles a memory access may wait for mem_ready before a bus-error trap. 0 disables the watchdog.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- op  input  OPW  opcode from the instruction register
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- pcwrite  output  1  unconditional PC load
- branch  output  1  conditional PC load, qualified by ALU zero in the datapath
- regwrite  output  1  register file write
- regdst  output  1  write register: 0=rt, 1=rd
- memtoreg  output  1  writeback data: 0=ALUOut, 1=MDR
- alusrca  output  1  ALU A: 0=PC, 1=rs
- alusrcb  output  2  ALU B: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- pcsrc  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- aluop  output  2  00=add, 01=sub, 10=use funct
- instr_done  output  1  one-cycle pulse on instruction retirement
- illegal  output  1  sticky trap flag (bad opcode or bus timeout)
- bus_err  output  1  sticky; set when the trap cause was a timeout
- state  output  4  current state, for debug

Behaviour:
- Registered 4-bit state; all outputs are Moore decodes of state, except the gated handshake strobes noted below.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12.
- Reset (reset==0 at a clock edge): state<=FETCH, illegal<=0, bus_err<=0, wait counter<=0.
  - Reset overrides every transition, including TRAP and mid-wait memory accesses.
  - While reset is low, every output is 0, state output included.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready (gated).
  - Go to DECODE when mem_ready=1; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 000000 -> RTYPEEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other value -> TRAP, setting illegal
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD if op==100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, all held every cycle until mem_ready. Then -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcwrite=1, pcsrc=10 -> FETCH.
- TRAP: all strobes 0, mem_req=0; illegal=1 held until reset.
- instr_done=1 in the final cycle of each instruction:
  - MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX
  - MEMWR when mem_ready=1
- Watchdog (MAX_WAIT>0):
  - Counter clears on every cycle where mem_req=0 or mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0, saturating at MAX_WAIT.
  - Counter==MAX_WAIT with mem_ready still 0 -> TRAP next cycle, with illegal=1 and bus_err=1.
  - A mem_ready arriving in that same cycle wins: normal transition, no trap.
- Cycle counts with zero wait states:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- op is sampled only in DECODE and MEMADR; op changes in other states are ignored.

Test Plan:
- Reset held low 3 cycles, then high, mem_ready=1, op=000000 -> all outputs 0 during reset; states 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7; instr_done pulses once.
- op=100011, mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; memtoreg=1 and regwrite=1 in state 4; irwrite=1 only in the FETCH cycle with mem_ready=1.
- op=101011, mem_ready=1 -> states 0,1,2,5,0; memwrite=1 and iord=1 for exactly one cycle; instr_done=1 in that cycle.
- op=000100, then op=000010 -> BEQEX drives branch=1, pcsrc=01, aluop=01; JEX drives pcwrite=1, pcsrc=10; each instruction takes 3 cycles.
- op=111111 at DECODE -> state 12, illegal=1, bus_err=0, all strobes stay 0 for 20 cycles; reset low for one cycle -> state 0, illegal=0.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH -> TRAP entered on the 6th cycle after entering FETCH, illegal=1, bus_err=1. Rerun with mem_ready=1 exactly when the counter reaches 4 -> DECODE, no trap.
